// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control path: opcodes, IR field
// positions, sequencer states and instruction classes.
package mini_src_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_DECODE,
    S_EX1, S_EX2, S_EX3, S_EX4, S_EX5, S_MEMW, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_MEM, CLS_BR,
    CLS_JR, CLS_IO, CLS_MOVE, CLS_NOP, CLS_HALT
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps a 5-bit opcode to the instruction class that selects the
// micro-step sequence in the control unit.
module instr_class_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] cls
);

  always_comb begin
    cls = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      cls = CLS_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:             cls = CLS_IMM;
      OP_MUL, OP_DIV:                       cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                       cls = CLS_UNARY;
      OP_LD, OP_LDI, OP_ST:                 cls = CLS_MEM;
      OP_BR:                                cls = CLS_BR;
      OP_JR:                                cls = CLS_JR;
      OP_IN, OP_OUT:                        cls = CLS_IO;
      OP_MFHI, OP_MFLO:                     cls = CLS_MOVE;
      OP_HALT:                              cls = CLS_HALT;
      default:                              cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the Mini SRC datapath: fetch/decode/execute with
// optional memory wait states, one micro-step per clock.
module control_unit
  import mini_src_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
  output logic        MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        IncPC, Read, Write,
  output logic [4:0]  operation,
  output logic        Run
);

  localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT - 1);

  logic [4:0]   opcode;
  logic [3:0]   cls_bits;
  instr_class_t cls;
  state_t       state_reg, state_next, mem_from_reg, step, after;
  logic [7:0]   wait_cnt_reg;
  logic         done, mem_step, wait_done;
  logic         unused_ir;

  assign opcode    = IR[OPC_HI:OPC_LO];
  assign unused_ir = ^IR[OPC_LO-1:0];
  assign cls       = instr_class_t'(cls_bits);

  instr_class_decode u_decode (.opcode(opcode), .cls(cls_bits));

  // MEMW replays the step that entered it, so outputs and successor both
  // come from the remembered step rather than from MEMW itself.
  assign step = (state_reg == S_MEMW) ? mem_from_reg : state_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= S_RESET;
      mem_from_reg <= S_RESET;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_MEMW) begin
        if (state_reg != S_MEMW) begin
          mem_from_reg <= state_reg;
          wait_cnt_reg <= '0;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
      end
    end
  end

  always_comb begin
    after = S_T0;
    done  = 1'b0;
    case (step)
      S_RESET:  after = S_T0;
      S_T0:     after = S_T1;
      S_T1:     after = S_T2;
      S_T2:     after = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_HALT: after = S_HALT;
          CLS_RALU, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_MEM, CLS_BR: after = S_EX1;
          default:  done = 1'b1;
        endcase
      end
      S_EX1:    if (cls == CLS_UNARY) done = 1'b1; else after = S_EX2;
      S_EX2:    if (cls == CLS_RALU || cls == CLS_IMM || opcode == OP_LDI) done = 1'b1;
                else after = S_EX3;
      S_EX3:    if (cls == CLS_MULDIV || cls == CLS_BR) done = 1'b1; else after = S_EX4;
      S_EX4:    done = 1'b1;
      S_HALT:   after = S_HALT;
      default:  after = S_T0;
    endcase
    if (done) after = Stop ? S_HALT : S_T0;

    mem_step   = (step == S_T1) || (step == S_EX3 && opcode == OP_LD) ||
                 (step == S_EX4 && opcode == OP_ST);
    wait_done  = (state_reg == S_MEMW) && (wait_cnt_reg == WAIT_LAST);
    state_next = (HAS_WAIT && mem_step && !wait_done) ? S_MEMW : after;
  end

  always_comb begin
    {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write} = '0;
    operation = 5'b00000;
    Run       = (state_reg != S_RESET) && (state_reg != S_HALT);
    case (step)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_DECODE: begin
        case (cls)
          CLS_RALU, CLS_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_UNARY:  begin Grb = 1'b1; Rout = 1'b1; operation = opcode; ZLOin = 1'b1; end
          CLS_MEM:    begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR:     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CLS_JR:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CLS_IO: begin
            Gra = 1'b1;
            if (opcode == OP_IN) begin InPortout = 1'b1; Rin = 1'b1; end
            else begin Rout = 1'b1; OutPortin = 1'b1; end
          end
          CLS_MOVE: begin
            HIout = (opcode == OP_MFHI); LOout = (opcode != OP_MFHI);
            Gra = 1'b1; Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX1: begin
        case (cls)
          CLS_RALU:   begin Grc = 1'b1; Rout = 1'b1; operation = opcode; ZLOin = 1'b1; end
          CLS_IMM:    begin Cout = 1'b1; operation = opcode; ZLOin = 1'b1; end
          CLS_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; operation = opcode; ZHIin = 1'b1; ZLOin = 1'b1;
          end
          CLS_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MEM:    begin Cout = 1'b1; operation = OP_ADD; ZLOin = 1'b1; end
          CLS_BR:     begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_EX2: begin
        case (cls)
          CLS_RALU, CLS_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          CLS_MEM: begin
            Zlowout = 1'b1;
            if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
            else MARin = 1'b1;
          end
          CLS_BR: begin Cout = 1'b1; operation = OP_ADD; ZLOin = 1'b1; end
          default: ;
        endcase
      end
      S_EX3: begin
        if (cls == CLS_MULDIV) begin ZHighout = 1'b1; HIin = 1'b1; end
        else if (cls == CLS_BR) begin Zlowout = CON_FF; PCin = CON_FF; end
        else if (opcode == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
        else if (opcode == OP_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_EX4: begin
        if (opcode == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (opcode == OP_ST) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
